service_protocol_mux_encoder: RTL

SERVICE_PROTOCOL_MUX_ENCODER -- requirements
Module: service_protocol_mux_encoder

---
 rtl/service_protocol_mux_encoder_pkg.sv | 41 ++++
 rtl/service_protocol_mux_encoder_if.sv | 32 +++
 rtl/service_protocol_mux_encoder_arbiter.sv | 43 ++++
 rtl/service_protocol_mux_encoder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/service_protocol_mux_encoder_pkg.sv
// ServiceProtocol: shared types for the service protocol mux encoder.
//   TCommandCode  - 8-bit command code carried in the second header word
//   THeaderPart   - the two header words built from addr/size/cmd
//   TState        - encoder FSM state encoding
//   make_header   - packs addr/size/cmd into THeaderPart
//   crc16_step    - CRC-16-CCITT (poly 0x1021) update for one 16-bit word, MSB first
package ServiceProtocol;

    typedef logic [7:0] TCommandCode;

    typedef struct packed {
        logic [15:0] hdr1;
        logic [15:0] hdr2;
    } THeaderPart;

    typedef enum logic [3:0] {
        IDLE, ARB, H1_L, H1_W, H2_L, H2_W, D_LR, D_LW, D_SR, D_SW,
        CRC_L, CRC_W, NUM_L, NUM_W, DONE
    } TState;

    function automatic THeaderPart make_header(logic [7:0] addr, logic [15:0] size,
                                               TCommandCode cmd);
        THeaderPart h;
        h.hdr1 = {addr, size[15:8]};
        h.hdr2 = {size[7:0], cmd};
        return h;
    endfunction

    function automatic logic [15:0] crc16_step(logic [15:0] crc, logic [15:0] word);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ word[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

endpackage

// File: rtl/service_protocol_mux_encoder_if.sv
// Handshake bundle between the encoder and its source FIFOs / packet sink.
//   src_req/src_done/src_data : per-channel pop request, completion and popped word
//   pkt_req/pkt_data/pkt_done : packet word push request, word and acceptance
// master = encoder side, slave = FIFO/sink side.
interface service_protocol_mux_encoder_if #(
    parameter int unsigned CH = 4
);
    logic [CH-1:0]       src_req;
    logic [CH-1:0]       src_done;
    logic [CH-1:0][15:0] src_data;
    logic                pkt_req;
    logic [15:0]         pkt_data;
    logic                pkt_done;

    modport master (
        output src_req,
        input  src_done,
        input  src_data,
        output pkt_req,
        output pkt_data,
        input  pkt_done
    );

    modport slave (
        input  src_req,
        output src_done,
        output src_data,
        input  pkt_req,
        input  pkt_data,
        output pkt_done
    );
endinterface

// File: rtl/service_protocol_mux_encoder_arbiter.sv
// sp_rr_arbiter: round-robin channel arbiter.
//   clk, nRst : clock, synchronous active-low reset
//   req       : per-channel request
//   advance   : take the current grant; the search then starts after it
//   grant     : granted channel index (first requester after the last grant)
//   valid     : some channel is requesting
module sp_rr_arbiter #(
    parameter int unsigned CH  = 4,
    parameter int unsigned CHW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           nRst,
    input  logic [CH-1:0]  req,
    input  logic           advance,
    output logic [CHW-1:0] grant,
    output logic           valid
);
    logic [CHW-1:0] ptr_q;
    logic [31:0]    idx;

    // Walk from farthest to nearest so the channel right after ptr_q wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = CH; i >= 1; i--) begin
            idx = (32'(ptr_q) + i) % CH;
            if (req[idx[CHW-1:0]]) begin
                grant = idx[CHW-1:0];
                valid = 1'b1;
            end
        end
    end

    // Reset to the last channel so channel 0 wins first.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            ptr_q <= CHW'(CH - 1);
        end else if (advance && valid) begin
            ptr_q <= grant;
        end
    end
endmodule

// File: rtl/service_protocol_mux_encoder.sv
// service_protocol_mux_encoder: serves CH source channels round-robin and emits one packet per
// request: hdr1, hdr2, size data words popped from the channel, a check word and a
// per-channel packet number.
//   clk, nRst          : clock, synchronous active-low reset
//   en/addr/size/cmd   : per-channel request level and packet fields
//   bus (master)       : src_* pop handshake and pkt_* push handshake
//   busy               : high from ARB through DONE
//   cur_ch             : channel being served
//   pkt_sent           : one-cycle pulse after the packet number word is accepted
// Build option: SP_ENCODER_CRC16_EN selects CRC-16-CCITT for the check word instead of the
// 16-bit additive sum.
module service_protocol_mux_encoder
    import ServiceProtocol::*;
#(
    parameter int unsigned CH  = 4,
    parameter int unsigned CHW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic [CH-1:0]         en,
    input  logic [CH-1:0][7:0]    addr,
    input  logic [CH-1:0][15:0]   size,
    input  TCommandCode [CH-1:0]  cmd,
    service_protocol_mux_encoder_if.master bus,
    output logic                  busy,
    output logic [CHW-1:0]        cur_ch,
    output logic                  pkt_sent
);
`ifdef SP_ENCODER_CRC16_EN
    localparam logic [15:0] ChkInit = 16'hFFFF;
`else
    localparam logic [15:0] ChkInit = 16'h0000;
`endif

    function automatic logic [15:0] chk_step(logic [15:0] c, logic [15:0] w);
`ifdef SP_ENCODER_CRC16_EN
        return crc16_step(c, w);
`else
        return c + w;
`endif
    endfunction

    TState               state_q, state_d;
    logic [CHW-1:0]      cur_q, cur_d;
    THeaderPart          hdr_q, hdr_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         chk_q, chk_d;
    logic [15:0]         dword_q, dword_d;
    logic [CH-1:0][15:0] num_q, num_d;
    logic [CH-1:0]       served_q, served_d;

    logic [CH-1:0]  eligible;
    logic [CHW-1:0] gnt;
    logic           gnt_valid;
    logic           arb_advance;

    assign eligible    = en & ~served_q;
    assign arb_advance = (state_q == ARB);

    sp_rr_arbiter #(
        .CH  (CH),
        .CHW (CHW)
    ) u_arb (
        .clk     (clk),
        .nRst    (nRst),
        .req     (eligible),
        .advance (arb_advance),
        .grant   (gnt),
        .valid   (gnt_valid)
    );

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        hdr_d    = hdr_q;
        cnt_d    = cnt_q;
        chk_d    = chk_q;
        dword_d  = dword_q;
        num_d    = num_q;
        served_d = served_q;
        case (state_q)
            IDLE: if (|eligible) state_d = ARB;
            ARB: begin
                // Eligibility may vanish between IDLE and ARB; fall back to IDLE then.
                if (gnt_valid) begin
                    cur_d      = gnt;
                    hdr_d      = make_header(addr[gnt], size[gnt], cmd[gnt]);
                    cnt_d      = size[gnt];
                    chk_d      = ChkInit;
                    num_d[gnt] = num_q[gnt] + 16'd1;
                    state_d    = H1_L;
                end else begin
                    state_d = IDLE;
                end
            end
            H1_L: begin
                chk_d   = chk_step(chk_q, hdr_q.hdr1);
                state_d = H1_W;
            end
            H1_W: if (bus.pkt_done) state_d = H2_L;
            H2_L: begin
                chk_d   = chk_step(chk_q, hdr_q.hdr2);
                state_d = H2_W;
            end
            H2_W: if (bus.pkt_done) state_d = (cnt_q == 16'd0) ? CRC_L : D_LR;
            D_LR: begin
                cnt_d   = cnt_q - 16'd1;
                state_d = D_LW;
            end
            D_LW: begin
                if (bus.src_done[cur_q]) begin
                    dword_d = bus.src_data[cur_q];
                    state_d = D_SR;
                end
            end
            D_SR: begin
                chk_d   = chk_step(chk_q, dword_q);
                state_d = D_SW;
            end
            D_SW:  if (bus.pkt_done) state_d = (cnt_q == 16'd0) ? CRC_L : D_LR;
            CRC_L: state_d = CRC_W;
            CRC_W: if (bus.pkt_done) state_d = NUM_L;
            NUM_L: state_d = NUM_W;
            NUM_W: if (bus.pkt_done) state_d = DONE;
            DONE: begin
                served_d[cur_q] = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Request withdrawn mid-packet: abandon it; the number already taken stays consumed.
        if (state_q != IDLE && state_q != ARB && state_q != DONE && !en[cur_q]) begin
            state_d = IDLE;
        end
        served_d = served_d & en;
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            hdr_q    <= '0;
            cnt_q    <= '0;
            chk_q    <= '0;
            dword_q  <= '0;
            num_q    <= '0;
            served_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            hdr_q    <= hdr_d;
            cnt_q    <= cnt_d;
            chk_q    <= chk_d;
            dword_q  <= dword_d;
            num_q    <= num_d;
            served_q <= served_d;
        end
    end

    always_comb begin
        bus.src_req  = '0;
        bus.pkt_req  = 1'b0;
        bus.pkt_data = '0;
        case (state_q)
            H1_L, H1_W: bus.pkt_data = hdr_q.hdr1;
            H2_L, H2_W: bus.pkt_data = hdr_q.hdr2;
            D_SR, D_SW: bus.pkt_data = dword_q;
            CRC_L, CRC_W: bus.pkt_data = chk_q;
            NUM_L, NUM_W: bus.pkt_data = num_q[cur_q];
            default: bus.pkt_data = '0;
        endcase
        bus.pkt_req = (state_q == H1_L) || (state_q == H2_L) || (state_q == D_SR) ||
                      (state_q == CRC_L) || (state_q == NUM_L);
        if (state_q == D_LR) bus.src_req[cur_q] = 1'b1;
    end

    assign busy     = (state_q != IDLE);
    assign cur_ch   = cur_q;
    assign pkt_sent = (state_q == DONE);
endmodule
